// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: opcode constants,
// the default reset PC, the prefetch FIFO entry layout and the immediate
// extraction helpers used by the optional predecoder (BRANCH_PREDICT_EN).
package fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // One prefetch FIFO entry: 1 + 32 + 32 = 65 bits
  typedef struct packed {
    logic        pred_taken;
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // J-type immediate, sign-extended, bit 0 always zero
  function automatic logic [31:0] j_imm(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // B-type immediate, sign-extended, bit 0 always zero
  function automatic logic [31:0] b_imm(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bundle between the fetch stage
// (master) and instruction memory (slave). Responses return in order.
interface fetch_unit_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO: DEPTH entries of {pred_taken, pc, inst}. Head is read
// straight from the storage registers. Flush beats push and pop; a push
// and a pop in the same cycle are both honoured even when full.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             push_data,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; flush empties without touching storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // The fetch credit scheme must never push into a full FIFO without a pop
  overflow_chk: assert property (@(posedge clk) disable iff (!reset)
    !(push && !flush && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the fetch PC, issues in-order requests to
// instruction memory, buffers returned words with their PCs and hands them
// to decode. A redirect flushes the buffer and drops responses in flight.
// Optional feature macro: BRANCH_PREDICT_EN (predecode JAL / backward
// branches and redirect fetch to their target).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic               clk,
  input  logic               reset,
  fetch_unit_if.master       imem,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_inst,
  output logic               if_pred_taken
);

  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(DEPTH) + 1;
  localparam int CRW = $clog2(DEPTH + MAX_OUTSTANDING + 1) + 1;

  logic [31:0]    fetch_pc;
  logic [31:0]    fetch_pc_n;
  logic [31:0]    rsp_pc;
  logic [31:0]    rsp_pc_n;
  logic [OW-1:0]  outstanding;
  logic [OW-1:0]  outstanding_n;
  logic [OW-1:0]  drop_cnt;
  logic [OW-1:0]  drop_cnt_n;
  logic [FCW-1:0] fifo_count;
  logic [FCW-1:0] fifo_count_n;
  logic           req_valid_q;
  logic           credit_ok;

  logic           accept;
  logic           rsp_live;
  logic           push;
  logic           pop;
  logic           pred_taken;
  logic           fifo_empty;
  fetch_entry_t   push_data;
  fetch_entry_t   head;

  assign imem.req_valid = req_valid_q;
  assign imem.req_addr  = fetch_pc;

  assign accept   = req_valid_q && imem.req_ready;
  assign rsp_live = imem.rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign push     = rsp_live;
  assign pop      = if_valid && if_ready && !redirect_valid;

  assign push_data = '{pred_taken: pred_taken, pc: rsp_pc, inst: imem.rsp_data};

`ifdef BRANCH_PREDICT_EN
  logic [6:0]  rsp_opcode;
  logic        is_jal;
  logic        is_bwd_branch;
  logic [31:0] pred_target;

  // Predecode the returning word: JAL and backward branches are taken
  always_comb begin
    rsp_opcode    = imem.rsp_data[6:0];
    is_jal        = (rsp_opcode == OP_JAL);
    is_bwd_branch = (rsp_opcode == OP_BRANCH) && imem.rsp_data[31];
    pred_taken    = rsp_live && (is_jal || is_bwd_branch);
    pred_target   = rsp_pc + (is_jal ? j_imm(imem.rsp_data)
                                     : b_imm(imem.rsp_data));
  end
`else
  assign pred_taken = 1'b0;
`endif

  // Next-state for PCs and counters; external redirect overrides everything
  always_comb begin
    outstanding_n = outstanding + OW'(accept) - OW'(imem.rsp_valid);
    fetch_pc_n    = accept ? fetch_pc + 32'd4 : fetch_pc;
    rsp_pc_n      = rsp_live ? rsp_pc + 32'd4 : rsp_pc;
    drop_cnt_n    = (imem.rsp_valid && (drop_cnt != '0)) ? drop_cnt - 1'b1
                                                         : drop_cnt;
`ifdef BRANCH_PREDICT_EN
    if (pred_taken) begin
      fetch_pc_n = pred_target;
      rsp_pc_n   = pred_target;
      drop_cnt_n = outstanding_n;
    end
`endif
    if (redirect_valid) begin
      fetch_pc_n = redirect_pc;
      rsp_pc_n   = redirect_pc;
      drop_cnt_n = outstanding_n;
    end
    fifo_count_n = redirect_valid ? '0
                 : fifo_count + FCW'(push) - FCW'(pop);
    credit_ok    = ((CRW'(fifo_count_n) + CRW'(outstanding_n) - CRW'(drop_cnt_n))
                    < CRW'(DEPTH))
                 && (outstanding_n < OW'(MAX_OUTSTANDING));
  end

  // Fetch state registers; request valid is registered from next-state credit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      req_valid_q <= 1'b0;
    end else begin
      fetch_pc    <= fetch_pc_n;
      rsp_pc      <= rsp_pc_n;
      outstanding <= outstanding_n;
      drop_cnt    <= drop_cnt_n;
      req_valid_q <= credit_ok;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data (push_data),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign if_valid      = !fifo_empty;
  assign if_pc         = head.pc;
  assign if_inst       = head.inst;
  // Stored flag is constant zero when predecode is not built in
  assign if_pred_taken = head.pred_taken;

  // Memory must never return more words than were requested
  rsp_underflow_chk: assert property (@(posedge clk) disable iff (!reset)
    !(imem.rsp_valid && (outstanding == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-cycle vectors for plain
// sequential fetch, then hand-written sequences for backpressure, redirects,
// PC wrap, JAL predecode and mid-operation reset.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_pred_taken;

  int errors = 0;
  int checks = 0;

  logic [31:0] pend_q[$];
  logic [31:0] acc_log[$];
  bit          rsp_hold = 1'b0;
  bit          jal_mode = 1'b0;

`ifdef BRANCH_PREDICT_EN
  localparam logic [31:0] EXP_AFTER_JAL = 32'h0000_0018;
  localparam logic        EXP_JAL_PRED  = 1'b1;
`else
  localparam logic [31:0] EXP_AFTER_JAL = 32'h0000_0014;
  localparam logic        EXP_JAL_PRED  = 1'b0;
`endif

  typedef struct {
    logic        if_ready;
    logic        exp_req_valid;
    logic [31:0] exp_req_addr;
    logic        exp_if_valid;
    logic [31:0] exp_if_pc;
  } vec_t;

  vec_t vecs[8];

  fetch_unit_if imem ();

  fetch_unit #(
    .RESET_PC        (32'h0000_0000),
    .DEPTH           (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem           (imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_pred_taken  (if_pred_taken)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: ADDI-shaped words tagged by address,
  // with "jal x0, +8" at 0x10 when jal_mode is set
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (jal_mode && (a == 32'h0000_0010)) return 32'h0080_006F;
    return {a[24:0], 7'b0010011};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // One clock: record the handshake at the edge, then model imem with a
  // fixed one-cycle in-order response latency
  task automatic cycle();
    logic        acc;
    logic [31:0] a;
    acc = imem.req_valid && imem.req_ready;
    a   = imem.req_addr;
    @(posedge clk);
    #1;
    if (acc) begin
      pend_q.push_back(a);
      acc_log.push_back(a);
    end
    if (!rsp_hold && (pend_q.size() > 0)) begin
      imem.rsp_valid = 1'b1;
      imem.rsp_data  = mem_word(pend_q.pop_front());
    end else begin
      imem.rsp_valid = 1'b0;
      imem.rsp_data  = 32'h0;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if_ready = v.if_ready;
    cycle();
  endtask

  task automatic doReset();
    reset          = 1'b0;
    imem.req_ready = 1'b1;
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b0;
    rsp_hold       = 1'b0;
    pend_q.delete();
    acc_log.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic waitValid(input string name, input int max_cycles);
    int n = 0;
    while (!if_valid && (n < max_cycles)) begin
      cycle();
      n++;
    end
    checkOutput({name, "_arrives"}, {31'd0, if_valid}, 32'd1);
  endtask

  initial begin
    logic [31:0] pcs[$];
    logic        preds[$];

    vecs[0] = '{1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0004};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0014, 1'b1, 32'h0000_0008};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_0018, 1'b1, 32'h0000_000C};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_001C, 1'b1, 32'h0000_0010};

    // Reset state of every output
    reset          = 1'b0;
    imem.req_ready = 1'b1;
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b0;
    #2;
    checkOutput("rst_req_valid", {31'd0, imem.req_valid}, 32'd0);
    checkOutput("rst_req_addr", imem.req_addr, 32'h0);
    checkOutput("rst_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rst_if_pc", if_pc, 32'h0);
    checkOutput("rst_if_inst", if_inst, 32'h0);
    checkOutput("rst_if_pred", {31'd0, if_pred_taken}, 32'd0);

    // Sequential fetch with a one-cycle decode stall, table driven
    $display("[TB] sequential fetch vectors");
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("seq%0d_req_valid", i), {31'd0, imem.req_valid},
                  {31'd0, vecs[i].exp_req_valid});
      checkOutput($sformatf("seq%0d_req_addr", i), imem.req_addr, vecs[i].exp_req_addr);
      checkOutput($sformatf("seq%0d_if_valid", i), {31'd0, if_valid},
                  {31'd0, vecs[i].exp_if_valid});
      if (vecs[i].exp_if_valid) begin
        checkOutput($sformatf("seq%0d_if_pc", i), if_pc, vecs[i].exp_if_pc);
        checkOutput($sformatf("seq%0d_if_inst", i), if_inst, mem_word(vecs[i].exp_if_pc));
      end
    end

    // Decode stalled: FIFO credit limits fetch to DEPTH words
    $display("[TB] backpressure");
    doReset();
    if_ready = 1'b0;
    repeat (12) cycle();
    checkOutput("bp_accept_count", 32'(acc_log.size()), 32'd4);
    checkOutput("bp_req_valid_low", {31'd0, imem.req_valid}, 32'd0);
    checkOutput("bp_head_pc", if_pc, 32'h0);
    if_ready = 1'b1;
    cycle();
    if_ready = 1'b0;
    checkOutput("bp_head_after_pop", if_pc, 32'h4);
    repeat (8) cycle();
    checkOutput("bp_accept_after_pop", 32'(acc_log.size()), 32'd5);
    checkOutput("bp_new_addr", (acc_log.size() > 4) ? acc_log[4] : 32'hDEAD_BEEF,
                32'h10);
    checkOutput("bp_req_valid_relow", {31'd0, imem.req_valid}, 32'd0);

    // Redirect with two requests outstanding: both late words dropped
    $display("[TB] redirect with outstanding requests");
    doReset();
    if_ready = 1'b1;
    rsp_hold = 1'b1;
    repeat (3) cycle();
    checkOutput("maxout_req_valid", {31'd0, imem.req_valid}, 32'd0);
    checkOutput("maxout_accepts", 32'(acc_log.size()), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    rsp_hold       = 1'b0;
    checkOutput("redir_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("redir_req_addr", imem.req_addr, 32'h100);
    waitValid("redir_out", 20);
    checkOutput("redir_first_pc", if_pc, 32'h100);
    checkOutput("redir_first_inst", if_inst, mem_word(32'h100));

    // Redirect in the same cycle as a response and a pop
    $display("[TB] redirect with coincident response and pop");
    doReset();
    if_ready = 1'b1;
    repeat (4) cycle();
    checkOutput("coinc_pre_valid", {31'd0, if_valid}, 32'd1);
    checkOutput("coinc_pre_pc", if_pc, 32'h4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    checkOutput("coinc_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("coinc_req_addr", imem.req_addr, 32'h100);
    waitValid("coinc_out", 20);
    checkOutput("coinc_first_pc", if_pc, 32'h100);

    // Redirect near the top of the address space: PC wraps to zero
    $display("[TB] PC wrap");
    doReset();
    if_ready = 1'b1;
    repeat (4) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    acc_log.delete();
    waitValid("wrap_out", 20);
    checkOutput("wrap_first_pc", if_pc, 32'hFFFF_FFFC);
    cycle();
    checkOutput("wrap_second_valid", {31'd0, if_valid}, 32'd1);
    checkOutput("wrap_second_pc", if_pc, 32'h0);
    checkOutput("wrap_addr0", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF,
                32'hFFFF_FFFC);
    checkOutput("wrap_addr1", (acc_log.size() > 1) ? acc_log[1] : 32'hDEAD_BEEF,
                32'h0);

    // JAL +8 at 0x10
    $display("[TB] JAL at 0x10");
    doReset();
    jal_mode = 1'b1;
    if_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (if_valid) begin
        pcs.push_back(if_pc);
        preds.push_back(if_pred_taken);
      end
    end
    checkOutput("jal_seen_count_ok", {31'd0, pcs.size() >= 6}, 32'd1);
    checkOutput("jal_prev_pred", {31'd0, (preds.size() > 3) ? preds[3] : 1'bx}, 32'd0);
    checkOutput("jal_pc", (pcs.size() > 4) ? pcs[4] : 32'hDEAD_BEEF, 32'h10);
    checkOutput("jal_pred", {31'd0, (preds.size() > 4) ? preds[4] : 1'bx},
                {31'd0, EXP_JAL_PRED});
    checkOutput("jal_next_pc", (pcs.size() > 5) ? pcs[5] : 32'hDEAD_BEEF, EXP_AFTER_JAL);
    jal_mode = 1'b0;

    // Asynchronous reset in the middle of streaming
    $display("[TB] mid-operation reset");
    reset = 1'b0;
    #1;
    checkOutput("midrst_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("midrst_req_valid", {31'd0, imem.req_valid}, 32'd0);
    checkOutput("midrst_req_addr", imem.req_addr, 32'h0);
    checkOutput("midrst_if_pc", if_pc, 32'h0);
    doReset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage in front of the decode stage. It owns the fetch PC, issues in-order requests to instruction memory over a valid/ready handshake, and buffers returned instructions with their PCs in a small prefetch FIFO. Decode drains the FIFO through a valid/ready interface. A redirect from execute (branch/jump resolution) flushes the FIFO and discards responses still in flight.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 4, prefetch FIFO entries (power of two, ≥2)
MAX_OUTSTANDING, 2, maximum accepted imem requests without a response

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  imem accepts request
imem_req_addr  output  32  word-aligned fetch address
imem_rsp_valid  input  1  instruction returned (in order, ≥1 cycle after accept)
imem_rsp_data  input  32  instruction word
redirect_valid  input  1  execute redirects fetch
redirect_pc  input  32  new fetch address
if_valid  output  1  FIFO head valid
if_ready  input  1  decode consumes head
if_pc  output  32  PC of head instruction
if_inst  output  32  head instruction
if_pred_taken  output  1  head was predicted taken (see Optional Feature)

Behaviour:
- Reset (reset==0, async): fetch_pc=RESET_PC, rsp_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0, if_pred_taken=0.
- Request issue: imem_req_valid=1 when (fifo_count + outstanding − drop_cnt) < DEPTH and outstanding < MAX_OUTSTANDING. imem_req_addr=fetch_pc. Accept (valid&&ready) → fetch_pc+=4 and outstanding+=1. Address holds until accepted unless a redirect occurs.
- Response: imem_rsp_valid → outstanding−=1. If drop_cnt>0, the word is discarded and drop_cnt−=1. Otherwise {rsp_pc, data} is pushed and rsp_pc+=4. The credit rule guarantees no push into a full FIFO; an overflow is an assertion failure.
- Output: if_valid = !empty, and head fields are registered. A response in cycle N appears on if_valid in cycle N+1. Pop on if_valid&&if_ready. Push and pop in the same cycle are both honoured at any occupancy.
- Redirect in cycle N (highest priority):
  - FIFO cleared.
  - fetch_pc=rsp_pc=redirect_pc.
  - drop_cnt = outstanding + (accept in N) − (rsp in N).
  - Any response in N is dropped.
  - Any pop in N is ignored.
  - In cycle N+1: if_valid=0 and imem_req_addr=redirect_pc.
- Back-to-back redirects: the last one wins. drop_cnt is recomputed each time per the formula above.
- PC arithmetic is modulo 2^32. 0xFFFF_FFFC+4 wraps to 0.
- A mid-operation reset discards all state immediately. Responses arriving after reset release for pre-reset requests are a system error and are not tolerated.

Optional Feature:
BRANCH_PREDICT_EN
- Defined: each live response is predecoded before push.
  - JAL (opcode 7'b1101111) is predicted taken with target rsp_pc + J-imm.
  - B-type (opcode 7'b1100011) with imm[12]==1 (backward) is predicted taken with target rsp_pc + B-imm.
  - A predicted-taken instruction is pushed with pred_taken=1, then an internal redirect to the target applies the same rules as an external one, except the FIFO is not cleared.
  - An external redirect in the same cycle has priority over the internal one.
- Undefined: no predecode logic; if_pred_taken tied 0; fetch is strictly sequential.

Decomposition:
- Shared package: opcode constants (OP_JAL, OP_BRANCH), the RESET_PC default, and the immediate-extraction functions for J and B types.
- Sub-module fetch_fifo: parameterised DEPTH×65-bit synchronous FIFO with push, pop, flush and count.

Test Plan:
- Reset release, imem ready always, 1-cycle latency, if_ready=1 → requests at 0x0, 0x4, 0x8…; if_pc sequence 0x0, 0x4, 0x8 with matching if_inst; first if_valid exactly 3 cycles after reset release.
- if_ready=0 with DEPTH=4 → exactly 4 requests accepted; imem_req_valid stays 0 until one pop; each pop then allows exactly one new request.
- Redirect to 0x100 with 2 requests outstanding → both late responses dropped; next if_pc=0x100; no stale instruction ever reaches if_valid.
- Redirect coincident with a response and a pop → response dropped, FIFO empty in the next cycle, imem_req_addr=0x100.
- Redirect to 0xFFFF_FFFC → fetch addresses 0xFFFF_FFFC then 0x0000_0000.
- BRANCH_PREDICT_EN defined, JAL +8 at 0x10 → if_pred_taken=1 at if_pc 0x10, next live if_pc=0x18; undefined → next if_pc=0x14 and if_pred_taken=0.
